uart_rx_param: RTL and testbench
================================

Name: uart_rx_param

Overview:
Parametrised UART receiver. It converts an asynchronous serial line into parallel words with a ready/valid output handshake.
- Configurable clock and baud rate, data width, parity mode and stop-bit count.
- Mid-bit sampling, start-bit glitch rejection, and framing, parity and overrun detection.
- Sits between the board RX pin and lab consumers such as the FSM and display logic.

Parameters:
- CLK_HZ, 50_000_000, system clock frequency in Hz.
- BAUD, 9600, line rate. CLKS_PER_BIT = CLK_HZ/BAUD, truncated (5208 at the defaults). HALF_BIT = CLKS_PER_BIT/2.
- DATA_BITS, 8, word width, legal range 5..9.
- PARITY, 0, 0 = none, 1 = odd, 2 = even.
- STOP_BITS, 1, legal values 1 or 2.

Ports:
- clk_i  in  1  system clock.
- rst_i  in  1  reset, asynchronous, active-low.
- rx_i  in  1  raw serial line, idle high, asynchronous to clk_i.
- data_o  out  DATA_BITS  received word, LSB received first.
- valid_o  out  1  data_o and error flags are valid; held until accepted.
- ready_i  in  1  consumer accepts the word when valid_o & ready_i.
- frame_err_o  out  1  a stop bit was sampled low; qualified by valid_o.
- parity_err_o  out  1  parity mismatch; qualified by valid_o; always 0 when PARITY=0.
- overrun_o  out  1  one-cycle pulse: an unaccepted word was overwritten.
- busy_o  out  1  state != IDLE.

Behaviour:
- Reset values:
  - Outputs: data_o=0, valid_o=0, frame_err_o=0, parity_err_o=0, overrun_o=0, busy_o=0.
  - Internal: FSM in IDLE, counters 0.
  - Synchroniser flops reset to 1, so no false start bit is seen after reset.
- Input path: rx_i passes through a 2-flop synchroniser giving rx_s. A previous-value flop provides falling-edge detection.
- FSM states: IDLE, START, DATA, PAR, STOP.
- IDLE: a falling edge on rx_s (1 -> 0) moves to START and clears the bit counter. A line held low (break) never re-arms the receiver; rx_s must return high first.
- START: at count HALF_BIT-1, rx_s is sampled.
  - rx_s=1: glitch; return to IDLE, no output.
  - rx_s=0: clear the counter, enter DATA.
- DATA: rx_s is sampled at count CLKS_PER_BIT-1 and shifted in LSB-first, DATA_BITS samples in total. Next state is PAR if PARITY != 0, otherwise STOP.
- PAR: one sample at CLKS_PER_BIT-1. parity_err = (XOR of data bits ^ sampled bit) != (PARITY==1), i.e. odd parity requires the XOR of data and parity bits to be 1, even parity requires 0.
- STOP: STOP_BITS samples, each at CLKS_PER_BIT-1. frame_err is set if any stop sample is 0.
  - On the last stop sample: load data_o and the error flags, set valid_o, go to IDLE in the same cycle.
  - Returning at mid-stop allows a back-to-back start edge half a bit later.
- Latency: valid_o rises on the clock edge following the last stop-bit sample. Nominally (1.5 + DATA_BITS + P + STOP_BITS - 1) * CLKS_PER_BIT + 3 cycles after the rx_i falling edge, where P is 1 when parity is enabled and 0 otherwise, ±1 cycle of synchroniser uncertainty.
- Handshake:
  - valid_o clears on the edge where valid_o & ready_i.
  - data_o and the flags are stable while valid_o=1 and no new frame completes.
- Overrun: a frame completes while valid_o=1 and ready_i=0.
  - data_o and the flags are overwritten with the new frame.
  - valid_o stays 1.
  - overrun_o pulses for 1 cycle.
- Simultaneous completion and handshake: no overrun; valid_o stays 1 carrying the new word.
- Frames with frame or parity errors are still delivered; errors never suppress valid_o.
- Counter widths: bit-timing counter is $clog2(CLKS_PER_BIT) bits; bit index is $clog2(DATA_BITS+1) bits. No counter may wrap before its compare value.
- Reset mid-frame: immediate return to IDLE and all outputs to their reset values; the partial frame is discarded.
- Elaboration fails (assertion) if CLKS_PER_BIT < 4, DATA_BITS is outside 5..9, PARITY > 2, or STOP_BITS is not 1 or 2.

Decomposition:
- Package uart_pkg holds:
  - rx_state_t enum (IDLE, START, DATA, PAR, STOP).
  - Parity constants PAR_NONE, PAR_ODD, PAR_EVEN.
  - Function clks_per_bit(clk_hz, baud).
- One sub-module, uart_bit_timer: the bit-timing counter with restart input, half-bit and full-bit tick outputs, parametrised by CLKS_PER_BIT. It is reused by the future uart_tx_param.

Test Plan:
1. Basic receive: CLK_HZ=1_000_000, BAUD=100_000 (10 clocks/bit), 8N1, send 0xA5 with ready_i=1 -> one valid_o cycle with data_o=0xA5, both error flags 0, overrun_o=0.
2. Start-glitch rejection: rx_i low for 3 clocks then high -> FSM returns to IDLE, valid_o never asserts, busy_o high for at most 7 cycles.
3. Parity: PARITY=2, send 0x37 with a correct parity bit (1) -> parity_err_o=0. Resend with the parity bit flipped -> data_o=0x37 and parity_err_o=1.
4. Framing and break: 8N2, send 0x5A with the second stop bit low -> frame_err_o=1, data_o=0x5A. Then hold rx_i low for 50 bit times -> no further valid_o until rx_i returns high and a new start bit arrives.
5. Overrun and handshake: ready_i=0, send 0x11 then 0x22 back-to-back -> overrun_o pulses once and data_o=0x22. Assert ready_i for 1 cycle -> valid_o drops.
6. Reset mid-frame: assert rst_i during DATA bit 3, release, then send 0xC3 -> outputs at reset values during reset, next frame received correctly as 0xC3.

Source files
------------

// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : uart_pkg
//  Description : Shared types and helpers for the UART receiver/transmitter
//                family: FSM state encoding, parity mode codes and the
//                clocks-per-bit calculation.
//  Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

    // Receiver FSM states
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        PAR   = 3'd3,
        STOP  = 3'd4
    } rx_state_t;

    // Parity mode codes for the PARITY parameter
    localparam int PAR_NONE = 0;
    localparam int PAR_ODD  = 1;
    localparam int PAR_EVEN = 2;

    // Whole system clocks per serial bit (truncated)
    function automatic int clks_per_bit(input int clk_hz, input int baud);
        return clk_hz / baud;
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_bit_timer.sv
`default_nettype none
// ============================================================================
//  Module      : uart_bit_timer
//  Description : Free-running bit-period counter. Restart clears it; it wraps
//                after CLKS_PER_BIT clocks. Emits a tick at mid-bit
//                (HALF_BIT-1) and at the end of the bit (CLKS_PER_BIT-1).
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_bit_timer #(
    parameter int CLKS_PER_BIT = 5208
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic restart_i,
    output logic half_tick_o,
    output logic full_tick_o
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] c_half_cnt = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] c_full_cnt = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] r_cnt;

    // Bit-period counter: restart has priority, wrap at the full-bit count
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_cnt <= '0;
        end else if (restart_i || (r_cnt == c_full_cnt)) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign half_tick_o = (r_cnt == c_half_cnt);
    assign full_tick_o = (r_cnt == c_full_cnt);

endmodule
`default_nettype wire

// File: rtl/uart_rx_param.sv
`default_nettype none
// ============================================================================
//  Module      : uart_rx_param
//  Description : Parametrised UART receiver. Synchronises the serial line,
//                samples each bit at its centre, checks parity and stop bits
//                and presents words on a ready/valid interface with framing,
//                parity and overrun status.
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_param
    import uart_pkg::*;
#(
    parameter int CLK_HZ    = 50_000_000,
    parameter int BAUD      = 9600,
    parameter int DATA_BITS = 8,
    parameter int PARITY    = 0,
    parameter int STOP_BITS = 1
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 rx_i,
    output logic [DATA_BITS-1:0] data_o,
    output logic                 valid_o,
    input  logic                 ready_i,
    output logic                 frame_err_o,
    output logic                 parity_err_o,
    output logic                 overrun_o,
    output logic                 busy_o
);

    localparam int CLKS_PER_BIT = clks_per_bit(CLK_HZ, BAUD);
    localparam int IDX_W        = $clog2(DATA_BITS + 1);

    localparam logic [IDX_W-1:0] c_last_data = IDX_W'(DATA_BITS - 1);
    localparam logic [IDX_W-1:0] c_last_stop = IDX_W'(STOP_BITS - 1);
    localparam logic             c_odd_par   = (PARITY == PAR_ODD);

    // Reject configurations the datapath cannot support
    generate
        if (CLKS_PER_BIT < 4) begin : g_bad_clks
            $error("uart_rx_param: CLKS_PER_BIT must be at least 4");
        end
        if ((DATA_BITS < 5) || (DATA_BITS > 9)) begin : g_bad_width
            $error("uart_rx_param: DATA_BITS must be in 5..9");
        end
        if ((PARITY < 0) || (PARITY > 2)) begin : g_bad_parity
            $error("uart_rx_param: PARITY must be 0, 1 or 2");
        end
        if ((STOP_BITS != 1) && (STOP_BITS != 2)) begin : g_bad_stop
            $error("uart_rx_param: STOP_BITS must be 1 or 2");
        end
    endgenerate

    rx_state_t            r_state;
    logic                 r_rx_meta;
    logic                 r_rx_s;
    logic                 r_rx_prev;
    logic [IDX_W-1:0]     r_bit_idx;
    logic [DATA_BITS-1:0] r_shift;
    logic                 r_frame_acc;
    logic                 r_par_acc;
    logic [DATA_BITS-1:0] r_data;
    logic                 r_valid;
    logic                 r_frame_err;
    logic                 r_parity_err;
    logic                 r_overrun;

    logic w_fall;
    logic w_restart;
    logic w_half_tick;
    logic w_full_tick;
    logic w_par_err;

    // Two-flop synchroniser plus a history flop for edge detection; all reset
    // high so the idle line never looks like a start bit after reset
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_rx_meta <= 1'b1;
            r_rx_s    <= 1'b1;
            r_rx_prev <= 1'b1;
        end else begin
            r_rx_meta <= rx_i;
            r_rx_s    <= r_rx_meta;
            r_rx_prev <= r_rx_s;
        end
    end

    assign w_fall = r_rx_prev & ~r_rx_s;

    // Timer is held at zero while idle and realigned once the start bit has
    // been confirmed, so every later sample lands at mid-bit
    assign w_restart = (r_state == IDLE) || ((r_state == START) && w_half_tick);

    uart_bit_timer #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_bit_timer (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .restart_i   (w_restart),
        .half_tick_o (w_half_tick),
        .full_tick_o (w_full_tick)
    );

    // Odd parity wants the XOR of data and parity bit to be 1, even wants 0
    assign w_par_err = ((^r_shift) ^ r_rx_s) != c_odd_par;

    // Receive FSM with registered output word, flags and handshake
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_state      <= IDLE;
            r_bit_idx    <= '0;
            r_shift      <= '0;
            r_frame_acc  <= 1'b0;
            r_par_acc    <= 1'b0;
            r_data       <= '0;
            r_valid      <= 1'b0;
            r_frame_err  <= 1'b0;
            r_parity_err <= 1'b0;
            r_overrun    <= 1'b0;
        end else begin
            r_overrun <= 1'b0;
            if (r_valid && ready_i) begin
                r_valid <= 1'b0;
            end

            case (r_state)
                IDLE: begin
                    if (w_fall) begin
                        r_state   <= START;
                        r_bit_idx <= '0;
                    end
                end

                START: begin
                    if (w_half_tick) begin
                        if (r_rx_s) begin
                            r_state <= IDLE;
                        end else begin
                            r_state     <= DATA;
                            r_bit_idx   <= '0;
                            r_frame_acc <= 1'b0;
                            r_par_acc   <= 1'b0;
                        end
                    end
                end

                DATA: begin
                    if (w_full_tick) begin
                        r_shift <= {r_rx_s, r_shift[DATA_BITS-1:1]};
                        if (r_bit_idx == c_last_data) begin
                            r_bit_idx <= '0;
                            r_state   <= (PARITY != PAR_NONE) ? PAR : STOP;
                        end else begin
                            r_bit_idx <= r_bit_idx + IDX_W'(1);
                        end
                    end
                end

                PAR: begin
                    if (w_full_tick) begin
                        r_par_acc <= w_par_err;
                        r_state   <= STOP;
                    end
                end

                STOP: begin
                    if (w_full_tick) begin
                        if (r_bit_idx == c_last_stop) begin
                            // Return to IDLE at mid-stop so a back-to-back
                            // start edge is caught half a bit later
                            r_data       <= r_shift;
                            r_frame_err  <= r_frame_acc | ~r_rx_s;
                            r_parity_err <= r_par_acc;
                            r_valid      <= 1'b1;
                            r_overrun    <= r_valid & ~ready_i;
                            r_state      <= IDLE;
                        end else begin
                            r_frame_acc <= r_frame_acc | ~r_rx_s;
                            r_bit_idx   <= r_bit_idx + IDX_W'(1);
                        end
                    end
                end

                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign data_o       = r_data;
    assign valid_o      = r_valid;
    assign frame_err_o  = r_frame_err;
    assign parity_err_o = r_parity_err;
    assign overrun_o    = r_overrun;
    assign busy_o       = (r_state != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_param.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : tb_uart_rx_param
//  Description : Scoreboard bench for uart_rx_param. Two receivers at 10
//                clocks/bit: an 8N1 instance and an 8E2 instance.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_rx_param;

    localparam int CLK_HZ = 1_000_000;
    localparam int BAUD   = 100_000;
    localparam int CPB    = CLK_HZ / BAUD;

    typedef struct {
        logic [7:0] data;
        bit         perr;
        bit         ferr;
        bit         ovr;
        int         start;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rx    [2];
    logic       ready [2];
    logic [7:0] dout  [2];
    logic       valid [2];
    logic       ferr  [2];
    logic       perr  [2];
    logic       ovr   [2];
    logic       busy  [2];

    exp_t q0[$];
    exp_t q1[$];

    int n_checks = 0;
    int n_err    = 0;
    int cyc      = 0;

    logic       pv    [2];
    logic       hs    [2];
    logic [7:0] pdata [2];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    uart_rx_param #(
        .CLK_HZ(CLK_HZ), .BAUD(BAUD), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)
    ) u_dut_8n1 (
        .clk_i(clk), .rst_i(rst_n), .rx_i(rx[0]), .data_o(dout[0]),
        .valid_o(valid[0]), .ready_i(ready[0]), .frame_err_o(ferr[0]),
        .parity_err_o(perr[0]), .overrun_o(ovr[0]), .busy_o(busy[0])
    );

    uart_rx_param #(
        .CLK_HZ(CLK_HZ), .BAUD(BAUD), .DATA_BITS(8), .PARITY(2), .STOP_BITS(2)
    ) u_dut_8e2 (
        .clk_i(clk), .rst_i(rst_n), .rx_i(rx[1]), .data_o(dout[1]),
        .valid_o(valid[1]), .ready_i(ready[1]), .frame_err_o(ferr[1]),
        .parity_err_o(perr[1]), .overrun_o(ovr[1]), .busy_o(busy[1])
    );

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chk_range(input string name, input int act, input int lo, input int hi);
        n_checks++;
        if ((act < lo) || (act > hi)) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d..%0d (t=%0t)", name, act, lo, hi, $time);
        end
    endtask

    // Handshake seen at the edge just taken
    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) hs[i] <= valid[i] & ready[i];
    end

    // Monitor: a new word is presented when valid rises, follows an accept,
    // or comes with an overrun pulse
    task automatic mon(input int i);
        exp_t e;
        bit   newp;
        int   nom;
        nom  = CPB + CPB / 2 + (8 + i + (i + 1) - 1) * CPB + 3;
        newp = valid[i] && (!pv[i] || hs[i] || ovr[i]);
        if (ovr[i] && !valid[i]) chk($sformatf("dut%0d overrun_without_valid", i), 1, 0);
        if (pv[i] && !valid[i]) chk($sformatf("dut%0d valid_drop_needs_accept", i), hs[i], 1);
        if (newp) begin
            if ((i == 0 && q0.size() == 0) || (i == 1 && q1.size() == 0)) begin
                chk($sformatf("dut%0d unexpected_word_%02h", i, dout[i]), 1, 0);
            end else begin
                e = (i == 0) ? q0.pop_front() : q1.pop_front();
                chk($sformatf("dut%0d data", i), dout[i], e.data);
                chk($sformatf("dut%0d parity_err", i), perr[i], e.perr);
                chk($sformatf("dut%0d frame_err", i), ferr[i], e.ferr);
                chk($sformatf("dut%0d overrun", i), ovr[i], e.ovr);
                chk_range($sformatf("dut%0d latency", i), cyc - e.start, nom - 1, nom + 1);
            end
        end else if (valid[i] && pv[i]) begin
            chk($sformatf("dut%0d data_stable", i), dout[i], pdata[i]);
        end
        pv[i]    = valid[i];
        pdata[i] = dout[i];
    endtask

    always @(negedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) begin
                pv[i]    = 1'b0;
                pdata[i] = 8'h00;
            end
        end else begin
            for (int i = 0; i < 2; i++) mon(i);
        end
    end

    // Reference frame: start, LSB-first data, even parity bit on dut1, stops.
    // stop_ok[k]=0 drives stop bit k low.
    task automatic send(input int i, input logic [7:0] d, input bit flip,
                        input bit [1:0] stop_ok, input bit exp_ovr, input bit hold_low);
        int   np;
        int   ns;
        bit   pbit;
        bit   b[$];
        exp_t e;
        np   = (i == 1) ? 1 : 0;
        ns   = (i == 1) ? 2 : 1;
        pbit = bit'($countones(d) % 2) ^ flip;
        b.push_back(1'b0);
        for (int k = 0; k < 8; k++) b.push_back(d[k]);
        if (np == 1) b.push_back(pbit);
        for (int k = 0; k < ns; k++) b.push_back(stop_ok[k]);
        e.data = d;
        e.perr = (np == 1) && ((($countones(d) + int'(pbit)) % 2) != 0);
        e.ferr = 1'b0;
        for (int k = 0; k < ns; k++) if (!stop_ok[k]) e.ferr = 1'b1;
        e.ovr   = exp_ovr;
        e.start = cyc;
        if (i == 0) q0.push_back(e);
        else        q1.push_back(e);
        foreach (b[k]) begin
            rx[i] = b[k];
            repeat (CPB) @(negedge clk);
        end
        if (!hold_low) rx[i] = 1'b1;
    endtask

    task automatic check_reset_outputs(input string tag);
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("%s dut%0d data_o", tag, i), dout[i], 0);
            chk($sformatf("%s dut%0d valid_o", tag, i), valid[i], 0);
            chk($sformatf("%s dut%0d frame_err_o", tag, i), ferr[i], 0);
            chk($sformatf("%s dut%0d parity_err_o", tag, i), perr[i], 0);
            chk($sformatf("%s dut%0d overrun_o", tag, i), ovr[i], 0);
            chk($sformatf("%s dut%0d busy_o", tag, i), busy[i], 0);
        end
    endtask

    task automatic random_frames(input int i, input int n);
        bit [1:0]   st;
        logic [7:0] d;
        int         gap;
        int         ns;
        ns = (i == 1) ? 2 : 1;
        for (int f = 0; f < n; f++) begin
            d   = 8'($urandom);
            st  = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(0, 2)) : 2'b11;
            send(i, d, bit'($urandom_range(0, 1)), st, 1'b0, 1'b0);
            gap = st[ns-1] ? $urandom_range(0, 2) : $urandom_range(1, 2);
            repeat (gap * CPB) @(negedge clk);
        end
    endtask

    initial begin
        int bc;
        for (int i = 0; i < 2; i++) begin
            rx[i]    = 1'b1;
            ready[i] = 1'b1;
        end
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst_n = 1'b1;
        repeat (2 * CPB) @(negedge clk);

        // 8N1 basic word and random traffic
        send(0, 8'hA5, 1'b0, 2'b11, 1'b0, 1'b0);
        repeat (CPB) @(negedge clk);
        random_frames(0, 8);
        repeat (2 * CPB) @(negedge clk);

        // Start-bit glitch: three low clocks then high
        bc = 0;
        rx[0] = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (k == 2) rx[0] = 1'b1;
            if (busy[0]) bc++;
        end
        chk_range("glitch busy cycles", bc, 1, 7);
        chk("glitch busy settled", busy[0], 0);
        repeat (2 * CPB) @(negedge clk);

        // Even parity: correct then flipped parity bit
        send(1, 8'h37, 1'b0, 2'b11, 1'b0, 1'b0);
        repeat (CPB) @(negedge clk);
        send(1, 8'h37, 1'b1, 2'b11, 1'b0, 1'b0);
        repeat (CPB) @(negedge clk);
        random_frames(1, 8);
        repeat (2 * CPB) @(negedge clk);

        // Second stop bit low, line then held low as a break
        send(1, 8'h5A, 1'b0, 2'b01, 1'b0, 1'b1);
        repeat (50 * CPB) @(negedge clk);
        chk("break busy", busy[1], 0);
        rx[1] = 1'b1;
        repeat (2 * CPB) @(negedge clk);
        send(1, 8'h3C, 1'b0, 2'b11, 1'b0, 1'b0);
        repeat (CPB) @(negedge clk);

        // Overrun: two back-to-back words with the consumer stalled
        ready[1] = 1'b0;
        send(1, 8'h11, 1'b0, 2'b11, 1'b0, 1'b0);
        send(1, 8'h22, 1'b0, 2'b11, 1'b1, 1'b0);
        chk("overrun valid held", valid[1], 1);
        chk("overrun data", dout[1], 8'h22);
        ready[1] = 1'b1;
        @(negedge clk);
        ready[1] = 1'b0;
        chk("valid after accept", valid[1], 0);
        repeat (CPB) @(negedge clk);

        // Reset during data bit 3 with an unaccepted word pending
        send(1, 8'h99, 1'b0, 2'b11, 1'b0, 1'b0);
        repeat (CPB) @(negedge clk);
        rx[1] = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            rx[1] = k[0];
            repeat (CPB) @(negedge clk);
        end
        rx[1] = 1'b1;
        repeat (CPB / 2) @(negedge clk);
        chk("busy before mid-frame reset", busy[1], 1);
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_outputs("midframe_reset");
        rst_n    = 1'b1;
        ready[1] = 1'b1;
        repeat (3 * CPB) @(negedge clk);
        send(1, 8'hC3, 1'b0, 2'b11, 1'b0, 1'b0);

        // Drain with a bounded wait
        for (int k = 0; k < 500 && (q0.size() + q1.size()) != 0; k++) @(negedge clk);
        chk("scoreboard drained", q0.size() + q1.size(), 0);
        repeat (CPB) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
